// File: rtl/mult_disp_pkg.sv
// Shared types and constants for the multiply-and-display controller.
// dabble_step performs one shift-add-3 iteration on the {BCD, binary} register.
package mult_disp_pkg;

  typedef enum logic [1:0] {IDLE, MULT, CONV, SHOW} state_t;

  localparam int CONV_CYCLES = 8;

  localparam logic [1:0] ONES     = 2'd0;
  localparam logic [1:0] TENS     = 2'd1;
  localparam logic [1:0] HUNDREDS = 2'd2;

  // Bits [19:8] hold three BCD nibbles and bits [7:0] hold the binary remainder.
  function automatic logic [19:0] dabble_step(input logic [19:0] r);
    logic [19:0] t;
    t = r;
    for (int i = 0; i < 3; i++) begin
      if (t[8 + 4*i +: 4] >= 4'd5)
        t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/mult_display_ctrl_if.sv
// Operand handshake and display bus for mult_display_ctrl.
interface mult_display_ctrl_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;
  logic [6:0] seg;
  logic [2:0] dig_en;

  modport master (output start, a, b, input busy, done, product, seg, dig_en);
  modport slave  (input start, a, b, output busy, done, product, seg, dig_en);
endinterface

// File: rtl/Multiplier4x4.sv
// Unsigned 4x4 combinational multiplier.
module Multiplier4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'b0, a} * {4'b0, b};
endmodule

// File: rtl/Seven_segment_Decoder.sv
// BCD to seven-segment pattern, active-high, bit order {g,f,e,d,c,b,a}; non-BCD codes go dark.
module Seven_segment_Decoder (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
  end
endmodule

// File: rtl/digit_scanner.sv
// Refresh counter and digit rotation for the shared decoder; registers the one-hot
// enable with leading-zero blanking. Driven from next-state values so dig_en is valid on SHOW entry.
module digit_scanner
  import mult_disp_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  output logic [1:0] idx,
  output logic [2:0] dig_en
);
  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          run_q;
  logic [2:0]    show;
  logic [2:0]    en_d;

  always_comb begin
    cnt_d = '0;
    idx_d = ONES;
    if (run && run_q) begin
      if (cnt_q == CW'(REFRESH_DIV - 1)) begin
        cnt_d = '0;
        idx_d = (idx_q == HUNDREDS) ? ONES : idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
      end
    end
  end

  // A blanked slot keeps its time share but drives no enable.
  always_comb begin
    show = 3'b111;
    if (BLANK_LEADING) begin
      if (hundreds == 4'd0)                  show[2] = 1'b0;
      if (hundreds == 4'd0 && tens == 4'd0)  show[1] = 1'b0;
    end
    en_d = 3'b000;
    if (run)
      en_d = (3'b001 << idx_d) & show;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= ONES;
      run_q  <= 1'b0;
      dig_en <= 3'b000;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      run_q  <= run;
      dig_en <= en_d;
    end
  end

  assign idx = idx_q;
endmodule

// File: rtl/mult_display_ctrl.sv
// Multiply-and-display sequencer: latch operands, multiply, double-dabble to BCD,
// then scan three digits through one shared seven-segment decoder.
//   state | meaning
//   IDLE  | waiting for start
//   MULT  | register product, load dabble register
//   CONV  | 8 shift-add-3 cycles
//   SHOW  | digits valid, display scanning; start restarts
module mult_display_ctrl
  import mult_disp_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic clk,
  input logic rst,
  mult_display_ctrl_if.slave bus
);
  state_t      state_q, state_d;
  logic [3:0]  a_r, b_r;
  logic [7:0]  product_q;
  logic [19:0] dab_q;
  logic [2:0]  bit_cnt_q;
  logic [3:0]  ones_q, tens_q, hund_q;
  logic [3:0]  ones_d, tens_d, hund_d;
  logic        busy_q, done_q;

  logic [7:0]  mult_p;
  logic [19:0] dab_next;
  logic        conv_last;
  logic        latch_ops;
  logic [1:0]  scan_idx;
  logic [2:0]  dig_en;
  logic [3:0]  dec_digit;
  logic [6:0]  dec_seg;

  Multiplier4x4 u_mult (.a(a_r), .b(b_r), .p(mult_p));

  assign dab_next  = dabble_step(dab_q);
  assign conv_last = (bit_cnt_q == 3'(CONV_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    latch_ops = 1'b0;
    ones_d    = ones_q;
    tens_d    = tens_q;
    hund_d    = hund_q;
    case (state_q)
      IDLE, SHOW: begin
        if (bus.start) begin
          latch_ops = 1'b1;
          state_d   = MULT;
        end
      end
      MULT: state_d = CONV;
      CONV: begin
        if (conv_last) begin
          ones_d  = dab_next[11:8];
          tens_d  = dab_next[15:12];
          hund_d  = dab_next[19:16];
          state_d = SHOW;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      product_q <= '0;
      dab_q     <= '0;
      bit_cnt_q <= '0;
      ones_q    <= '0;
      tens_q    <= '0;
      hund_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= (state_d == MULT) || (state_d == CONV);
      done_q <= (state_q == CONV) && conv_last;
      ones_q <= ones_d;
      tens_q <= tens_d;
      hund_q <= hund_d;
      if (latch_ops) begin
        a_r <= bus.a;
        b_r <= bus.b;
      end
      if (state_q == MULT) begin
        product_q <= mult_p;
        dab_q     <= {12'b0, mult_p};
        bit_cnt_q <= '0;
      end else if (state_q == CONV) begin
        dab_q     <= dab_next;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

  // Scanner sees next-state digits so blanking is right on the SHOW entry edge.
  digit_scanner #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_LEADING(BLANK_LEADING)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .run     (state_d == SHOW),
    .tens    (tens_d),
    .hundreds(hund_d),
    .idx     (scan_idx),
    .dig_en  (dig_en)
  );

  always_comb begin
    case (scan_idx)
      ONES:    dec_digit = ones_q;
      TENS:    dec_digit = tens_q;
      default: dec_digit = hund_q;
    endcase
  end

  Seven_segment_Decoder u_dec (.bcd(dec_digit), .seg(dec_seg));

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.dig_en  = dig_en;
  assign bus.seg     = (dig_en != 3'b000) ? dec_seg : 7'h00;
endmodule

// File: tb/tb_mult_display_ctrl.sv
// Directed bench: two instances (leading-zero blanking on and off) share one stimulus stream.
module tb_mult_display_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_s = 1'b0;
  logic [3:0] a_s = 4'd0;
  logic [3:0] b_s = 4'd0;
  int vectors = 0;
  int miscompares = 0;

  mult_display_ctrl_if bus1();
  mult_display_ctrl_if bus2();

  assign bus1.start = start_s;
  assign bus1.a     = a_s;
  assign bus1.b     = b_s;
  assign bus2.start = start_s;
  assign bus2.a     = a_s;
  assign bus2.b     = b_s;

  mult_display_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mult_display_ctrl #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Four scan slots of 4 cycles each, starting at the first SHOW cycle.
  task automatic check_scan(input logic [2:0][2:0] en1, input logic [2:0][6:0] seg1,
                            input logic [2:0][2:0] en2, input logic [2:0][6:0] seg2);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0 || c == 3) begin
          check($sformatf("dig_en_blank_s%0d_c%0d", s, c), bus1.dig_en, en1[s % 3]);
          check($sformatf("seg_blank_s%0d_c%0d", s, c),    bus1.seg,    seg1[s % 3]);
          check($sformatf("dig_en_full_s%0d_c%0d", s, c),  bus2.dig_en, en2[s % 3]);
          check($sformatf("seg_full_s%0d_c%0d", s, c),     bus2.seg,    seg2[s % 3]);
        end
        if (s == 0 && c == 1) check("done_width", bus1.done, 1'b0);
        @(negedge clk);
      end
    end
  endtask

  task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input int glitch,
                        input logic [7:0] exp_p,
                        input logic [2:0][2:0] en1, input logic [2:0][6:0] seg1,
                        input logic [2:0][2:0] en2, input logic [2:0][6:0] seg2);
    int n;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    a_s = av; b_s = bv; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    n = 0; busy_cnt = 0; seen = 1'b0;
    check("busy_after_start", bus1.busy, 1'b1);
    check("dig_en_off_while_busy", bus1.dig_en, 3'b000);
    while (n < 20 && !seen) begin
      if (bus1.busy) busy_cnt++;
      if (bus1.done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
        if (n == glitch) begin
          a_s = 4'd1; b_s = 4'd1; start_s = 1'b1;
        end else start_s = 1'b0;
      end
    end
    start_s = 1'b0;
    check("done_seen", seen, 1'b1);
    check("done_latency", n, 9);
    check("busy_cycles", busy_cnt, 9);
    check("done_full_inst", bus2.done, 1'b1);
    check("product", bus1.product, exp_p);
    check_scan(en1, seg1, en2, seg2);
  endtask

  initial begin
    int done_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy",    bus1.busy,    1'b0);
    check("rst_done",    bus1.done,    1'b0);
    check("rst_product", bus1.product, 8'd0);
    check("rst_dig_en",  bus1.dig_en,  3'b000);
    check("rst_seg",     bus1.seg,     7'h00);
    check("rst_dig_en2", bus2.dig_en,  3'b000);

    // 2*3 = 6
    run_op(4'd2, 4'd3, -1, 8'd6,
           {3'b000, 3'b000, 3'b001}, {7'h00, 7'h00, 7'h7D},
           {3'b100, 3'b010, 3'b001}, {7'h3F, 7'h3F, 7'h7D});
    // 15*15 = 225
    run_op(4'd15, 4'd15, -1, 8'hE1,
           {3'b100, 3'b010, 3'b001}, {7'h5B, 7'h5B, 7'h6D},
           {3'b100, 3'b010, 3'b001}, {7'h5B, 7'h5B, 7'h6D});
    // 12*10 = 120
    run_op(4'd12, 4'd10, -1, 8'd120,
           {3'b100, 3'b010, 3'b001}, {7'h06, 7'h5B, 7'h3F},
           {3'b100, 3'b010, 3'b001}, {7'h06, 7'h5B, 7'h3F});
    // 15*7 = 105: zero tens shown because hundreds is nonzero
    run_op(4'd15, 4'd7, -1, 8'd105,
           {3'b100, 3'b010, 3'b001}, {7'h06, 7'h3F, 7'h6D},
           {3'b100, 3'b010, 3'b001}, {7'h06, 7'h3F, 7'h6D});
    // 0*9 = 0
    run_op(4'd0, 4'd9, -1, 8'd0,
           {3'b000, 3'b000, 3'b001}, {7'h00, 7'h00, 7'h3F},
           {3'b100, 3'b010, 3'b001}, {7'h3F, 7'h3F, 7'h3F});
    // 7*9 = 63 with a stray start (1*1) during CONV
    run_op(4'd7, 4'd9, 4, 8'd63,
           {3'b000, 3'b010, 3'b001}, {7'h00, 7'h7D, 7'h4F},
           {3'b100, 3'b010, 3'b001}, {7'h3F, 7'h7D, 7'h4F});

    // Reset in the middle of CONV
    @(negedge clk);
    a_s = 4'd5; b_s = 4'd6; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_before_rst", bus1.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",    bus1.busy,    1'b0);
    check("midrst_done",    bus1.done,    1'b0);
    check("midrst_product", bus1.product, 8'd0);
    check("midrst_dig_en",  bus1.dig_en,  3'b000);
    check("midrst_seg",     bus1.seg,     7'h00);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus1.done) done_cnt++;
    end
    check("no_done_after_rst", done_cnt, 0);
    check("idle_after_rst_busy", bus1.busy, 1'b0);
    // 9*9 = 81
    run_op(4'd9, 4'd9, -1, 8'd81,
           {3'b000, 3'b010, 3'b001}, {7'h00, 7'h7F, 7'h06},
           {3'b100, 3'b010, 3'b001}, {7'h3F, 7'h7F, 7'h06});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
